// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the pipeline stage slices of the RISC-V core.
//   slice_state_e : occupancy state of a two-entry skid buffer
//   RV_NOP        : canonical NOP (addi x0, x0, 0), used as the bubble payload
//                   of the IF/ID slice
//   occupancy_of  : maps a slice state onto its entry count (0..2)
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } slice_state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Entry count held in a given state. The unused encoding 2'b11 reads as
    // empty so that a corrupted state can never claim to hold data.
    function automatic logic [1:0] occupancy_of(slice_state_e s);
        case (s)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// ---------------------------------------------------------------------------
// pipe_data_reg
//
// WIDTH-bit payload register with a load enable and a synchronous,
// active-high reset to RESET_VALUE. Used twice inside pipe_slice: once for
// the head (main) entry and once for the skid entry.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, loads RESET_VALUE
//   load  : when high, d is captured at the next edge
//   d     : data to capture
//   q     : registered data
// ---------------------------------------------------------------------------
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Hold the current value unless the owner asks for a load.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // Reset takes priority over any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_slice.sv
// ---------------------------------------------------------------------------
// pipe_slice
//
// Two-entry skid buffer used as a pipeline stage register. Both sides use a
// valid/ready handshake; every output is decoded from or taken directly out
// of a flop, so a downstream stall never reaches upstream combinationally.
// A flush empties the slice and parks FLUSH_VALUE (e.g. a NOP) on out_data.
//
// Parameters:
//   WIDTH       : payload width in bits
//   FLUSH_VALUE : out_data whenever the slice is empty
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   flush      : drop all held entries at the next edge
//   in_valid   : upstream offers in_data
//   in_ready   : slice can accept (low only when both entries are full)
//   in_data    : upstream payload
//   out_valid  : out_data holds a valid entry
//   out_ready  : downstream consumes out_data
//   out_data   : head entry, FLUSH_VALUE when empty
//   occupancy  : number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    slice_state_e     state_d;
    slice_state_e     state_q;

    logic             accept;
    logic             pop;

    logic             main_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;

    logic             skid_load;
    logic [WIDTH-1:0] skid_q;

    // Handshake outputs are pure decodes of the state flop.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = occupancy_of(state_q);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Next-state and register-load control. Whenever the slice drains to
    // EMPTY the main register is reloaded with FLUSH_VALUE, which keeps
    // out_data at the bubble value without a mux on the output path. The
    // skid register is written only when it has to absorb a word while the
    // head is stalled; otherwise its contents are irrelevant.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = in_data;
        skid_load = 1'b0;

        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b1;
            main_d    = FLUSH_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && !pop) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_d   = EMPTY;
                        main_load = 1'b1;
                        main_d    = FLUSH_VALUE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d   = BUSY;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: begin
                    state_d   = EMPTY;
                    main_load = 1'b1;
                    main_d    = FLUSH_VALUE;
                end
            endcase
        end
    end

    // State register; reset overrides flush and any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (FLUSH_VALUE)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (FLUSH_VALUE)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_slice.sv
// ---------------------------------------------------------------------------
// tb_pipe_slice
//
// Self-checking bench for pipe_slice. A 32-bit instance (FLUSH_VALUE 0x13)
// covers the directed scenarios; an 8-bit instance (FLUSH_VALUE 0xA5) takes
// the randomised valid/ready traffic. Accepted words are pushed into a
// scoreboard queue and popped when the slice hands a word downstream.
// ---------------------------------------------------------------------------
module tb_pipe_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        r_flush;
    logic        r_in_valid;
    logic        r_in_ready;
    logic [7:0]  r_in_data;
    logic        r_out_valid;
    logic        r_out_ready;
    logic [7:0]  r_out_data;
    logic [1:0]  r_occupancy;

    logic [31:0] sb[$];
    logic [7:0]  rsb[$];

    int total = 0;
    int bad   = 0;

    pipe_slice #(
        .WIDTH       (32),
        .FLUSH_VALUE (32'h13)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_slice #(
        .WIDTH       (8),
        .FLUSH_VALUE (8'hA5)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .flush     (r_flush),
        .in_valid  (r_in_valid),
        .in_ready  (r_in_ready),
        .in_data   (r_in_data),
        .out_valid (r_out_valid),
        .out_ready (r_out_ready),
        .out_data  (r_out_data),
        .occupancy (r_occupancy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held for two edges with a word offered; nothing may be captured.
    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        total++;
        if (out_data !== 32'h13) begin
            bad++;
            $display("[TB] FAIL reset_out_data: got %h expected 00000013", out_data);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        total++;
        if (occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        total++;
        if (r_out_valid !== 1'b0 || r_out_data !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL reset_dut8: got valid=%b data=%h expected valid=0 data=a5",
                     r_out_valid, r_out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_nothing_captured: got valid=%b occ=%0d expected valid=0 occ=0",
                     out_valid, occupancy);
        end
    endtask

    // Four words back to back with the consumer always ready.
    task automatic test_streaming();
        int          pops = 0;
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in_valid = (i <= 4);
            in_data  = (i <= 4) ? 32'(i) : 32'h0;
            if (i <= 4) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL stream_in_ready: got %b expected 1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                pops++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL stream_spurious: got %h expected no output", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        bad++;
                        $display("[TB] FAIL stream_order: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            tick();
            if (i <= 4) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                    bad++;
                    $display("[TB] FAIL stream_latency: got valid=%b data=%h expected valid=1 data=%h",
                             out_valid, out_data, 32'(i));
                end
            end
        end
        total++;
        if (pops != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stream_count: got pops=%0d left=%0d valid=%b expected pops=4 left=0 valid=0",
                     pops, sb.size(), out_valid);
        end
    endtask

    // Stall downstream until the slice fills, then drain.
    task automatic test_backpressure();
        int          pops = 0;
        logic        c_taken = 1'b0;
        logic        done = 1'b0;
        logic [31:0] exp;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        sb.push_back(in_data);
        tick();
        in_data = 32'hB;
        sb.push_back(in_data);
        tick();
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_full: got occ=%0d in_ready=%b expected occ=2 in_ready=0",
                     occupancy, in_ready);
        end
        in_data = 32'hC;
        tick();
        total++;
        if (out_data !== 32'hA || occupancy !== 2'd2 || out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_hold: got data=%h occ=%0d expected data=0000000a occ=2",
                     out_data, occupancy);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            in_valid = !c_taken;
            if (out_valid && out_ready) begin
                total++;
                pops++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL bp_spurious: got %h expected no output", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        bad++;
                        $display("[TB] FAIL bp_order: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                c_taken = 1'b1;
            end
            tick();
            done = c_taken && sb.size() == 0 && !out_valid;
        end
        in_valid = 1'b0;
        total++;
        if (!done || pops != 3) begin
            bad++;
            $display("[TB] FAIL bp_drain: got done=%b pops=%0d expected done=1 pops=3", done, pops);
        end
    endtask

    // Flush while FULL (input blocked) and while BUSY (input accepted, dropped).
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        flush   = 1'b1;
        in_data = 32'h55;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h13 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL flush_full: got valid=%b data=%h rdy=%b occ=%0d expected 0/00000013/1/0",
                     out_valid, out_data, in_ready, occupancy);
        end
        in_valid = 1'b1;
        in_data  = 32'h40;
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h55;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h13 || occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL flush_busy: got valid=%b data=%h occ=%0d expected 0/00000013/0",
                     out_valid, out_data, occupancy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || out_data !== 32'h13) begin
                bad++;
                $display("[TB] FAIL flush_dropped: got valid=%b data=%h expected valid=0 data=00000013",
                         out_valid, out_data);
            end
        end
    endtask

    // Accept and pop in the same cycle while BUSY.
    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        tick();
        in_data   = 32'h20;
        out_ready = 1'b1;
        total++;
        if (out_data !== 32'h10 || occupancy !== 2'd1) begin
            bad++;
            $display("[TB] FAIL b2b_before: got data=%h occ=%0d expected data=00000010 occ=1",
                     out_data, occupancy);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_data !== 32'h20 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_after: got data=%h occ=%0d valid=%b expected data=00000020 occ=1 valid=1",
                     out_data, occupancy, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h13) begin
            bad++;
            $display("[TB] FAIL b2b_drain: got valid=%b data=%h expected valid=0 data=00000013",
                     out_valid, out_data);
        end
    endtask

    // Random valid/ready on the 8-bit instance against a scoreboard.
    task automatic test_random();
        logic       hold = 1'b0;
        logic [7:0] hold_data = 8'h0;
        logic [7:0] exp;
        r_flush = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            r_in_valid  = ($urandom_range(0, 3) != 0);
            r_in_data   = 8'($urandom);
            r_out_ready = (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if (hold) begin
                total++;
                if (r_out_valid !== 1'b1 || r_out_data !== hold_data) begin
                    bad++;
                    $display("[TB] FAIL rand_stable: got valid=%b data=%h expected valid=1 data=%h",
                             r_out_valid, r_out_data, hold_data);
                end
            end
            if (r_out_valid && r_out_ready) begin
                total++;
                if (rsb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_spurious: got %h expected no output", r_out_data);
                end else begin
                    exp = rsb.pop_front();
                    if (r_out_data !== exp) begin
                        bad++;
                        $display("[TB] FAIL rand_order: got %h expected %h", r_out_data, exp);
                    end
                end
            end
            if (r_in_valid && r_in_ready) rsb.push_back(r_in_data);
            hold      = r_out_valid && !r_out_ready;
            hold_data = r_out_data;
            tick();
        end
        r_in_valid  = 1'b0;
        r_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (r_out_valid) begin
                total++;
                if (rsb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_drain_spurious: got %h expected no output", r_out_data);
                end else begin
                    exp = rsb.pop_front();
                    if (r_out_data !== exp) begin
                        bad++;
                        $display("[TB] FAIL rand_drain_order: got %h expected %h", r_out_data, exp);
                    end
                end
            end
            tick();
        end
        total++;
        if (rsb.size() != 0 || r_out_valid !== 1'b0 || r_out_data !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL rand_final: got left=%0d valid=%b data=%h expected left=0 valid=0 data=a5",
                     rsb.size(), r_out_valid, r_out_data);
        end
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        out_ready   = 1'b0;
        r_flush     = 1'b0;
        r_in_valid  = 1'b0;
        r_in_data   = 8'h0;
        r_out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
